fe_fetch_redirect: RTL and testbench



---
 rtl/fe_fetch_redirect_if.sv | 33 +++
 rtl/fe_fetch_redirect.sv | 66 ++++++
 tb/tb_fe_fetch_redirect.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fe_fetch_redirect_if.sv
// Fetch-side bundle: AGEX redirect, decode stall, instruction memory port and FE latch.
// master is the fetch block; slave is the surrounding pipeline/memory.
interface fe_fetch_redirect_if #(
   parameter int unsigned DBITS    = 32,
   parameter int unsigned INSTBITS = 32
);
   localparam int unsigned LatchBits = 1 + INSTBITS + 3 * DBITS + 4;

   logic [DBITS:0]          from_AGEX_to_FE;
   logic                    from_DE_to_FE;
   logic [DBITS-1:0]        imem_addr;
   logic [INSTBITS-1:0]     imem_rdata;
   logic [LatchBits-1:0]    FE_latch_out;
   logic [DBITS-1:0]        redirect_count;

   modport master (
      input  from_AGEX_to_FE,
      input  from_DE_to_FE,
      input  imem_rdata,
      output imem_addr,
      output FE_latch_out,
      output redirect_count
   );

   modport slave (
      output from_AGEX_to_FE,
      output from_DE_to_FE,
      output imem_rdata,
      input  imem_addr,
      input  FE_latch_out,
      input  redirect_count
   );
endinterface

// File: rtl/fe_fetch_redirect.sv
// Fetch stage: owns PC_FE, fills the FE latch, and restarts at the AGEX target on redirect.
// Priority each cycle: reset > redirect > decode stall > sequential fetch.
module fe_fetch_redirect #(
   parameter int unsigned DBITS    = 32,
   parameter int unsigned INSTBITS = 32,
   parameter logic [DBITS-1:0] STARTPC = 32'h0000_0000,
   parameter logic [3:0]       CANARY  = 4'hF
) (
   input logic clk,
   input logic reset,
   fe_fetch_redirect_if.master bus
);
   localparam int unsigned LatchBits = 1 + INSTBITS + 3 * DBITS + 4;

   logic                 br_cond;
   logic [DBITS-1:0]     br_target;
   logic                 stall;
   logic [DBITS-1:0]     pcplus;

   logic [DBITS-1:0]     pc_q, pc_d;
   logic [DBITS-1:0]     inst_count_q, inst_count_d;
   logic [DBITS-1:0]     redirect_count_q, redirect_count_d;
   logic [LatchBits-1:0] latch_q, latch_d;

   assign br_cond   = bus.from_AGEX_to_FE[DBITS];
   assign br_target = bus.from_AGEX_to_FE[DBITS-1:0];
   assign stall     = bus.from_DE_to_FE;
   assign pcplus    = pc_q + DBITS'(4);

   always_comb begin
      pc_d             = pc_q;
      inst_count_d     = inst_count_q;
      redirect_count_d = redirect_count_q;
      latch_d          = latch_q;
      if (br_cond) begin
         // Redirect wins over stall: the stalled instruction is itself wrong-path.
         pc_d    = br_target & ~DBITS'(3);
         latch_d = {{(LatchBits - 4){1'b0}}, CANARY};
         if (redirect_count_q != {DBITS{1'b1}}) begin
            redirect_count_d = redirect_count_q + DBITS'(1);
         end
      end else if (!stall) begin
         pc_d         = pcplus;
         inst_count_d = inst_count_q + DBITS'(1);
         latch_d      = {1'b1, bus.imem_rdata, pc_q, pcplus, inst_count_d, CANARY};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q             <= STARTPC;
         inst_count_q     <= '0;
         redirect_count_q <= '0;
         latch_q          <= {{(LatchBits - 4){1'b0}}, CANARY};
      end else begin
         pc_q             <= pc_d;
         inst_count_q     <= inst_count_d;
         redirect_count_q <= redirect_count_d;
         latch_q          <= latch_d;
      end
   end

   assign bus.imem_addr      = pc_q;
   assign bus.FE_latch_out   = latch_q;
   assign bus.redirect_count = redirect_count_q;
endmodule

// File: tb/tb_fe_fetch_redirect.sv
// Directed bench for fe_fetch_redirect: memory returns address-tagged words,
// expected latch contents are built from the PC and instruction ordinal.
module tb_fe_fetch_redirect;
   localparam logic [31:0] Tag    = 32'hDEAD_0000;
   localparam logic [3:0]  Canary = 4'hF;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fe_fetch_redirect_if #(.DBITS(32), .INSTBITS(32)) bus ();

   fe_fetch_redirect #(
      .DBITS   (32),
      .INSTBITS(32),
      .STARTPC (32'h0000_0000),
      .CANARY  (4'hF)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   assign bus.imem_rdata = bus.imem_addr ^ Tag;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [132:0] exp_valid(input logic [31:0] pc, input logic [31:0] cnt);
      logic [31:0] pcp;
      pcp = pc + 32'd4;
      return {1'b1, pc ^ Tag, pc, pcp, cnt, Canary};
   endfunction

   function automatic logic [132:0] exp_bubble();
      return {129'b0, Canary};
   endfunction

   task automatic check(input string tag, input logic [132:0] obs, input logic [132:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic br, input logic [31:0] tgt, input logic stall);
      bus.from_AGEX_to_FE = {br, tgt};
      bus.from_DE_to_FE   = stall;
   endtask

   task automatic expect_state(input string tag, input logic [31:0] addr,
                               input logic [132:0] latch, input logic [31:0] rc);
      check({tag, " addr"}, {101'b0, bus.imem_addr}, {101'b0, addr});
      check({tag, " latch"}, bus.FE_latch_out, latch);
      check({tag, " rcnt"}, {101'b0, bus.redirect_count}, {101'b0, rc});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      drive(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      tick();
      expect_state("reset", 32'h0, exp_bubble(), 32'd0);
      reset = 1'b0;

      // Sequential fetch from STARTPC
      tick(); expect_state("seq0", 32'h04, exp_valid(32'h00, 32'd1), 32'd0);
      tick(); expect_state("seq1", 32'h08, exp_valid(32'h04, 32'd2), 32'd0);
      tick(); expect_state("seq2", 32'h0C, exp_valid(32'h08, 32'd3), 32'd0);
      tick(); expect_state("seq3", 32'h10, exp_valid(32'h0C, 32'd4), 32'd0);

      // Redirect at PC 0x10 to 0x100
      drive(1'b1, 32'h100, 1'b0);
      tick(); expect_state("redir", 32'h100, exp_bubble(), 32'd1);
      drive(1'b0, 32'h0, 1'b0);
      tick(); expect_state("redir_tgt", 32'h104, exp_valid(32'h100, 32'd5), 32'd1);

      // Move to 0x1C so that PC sits at 0x20 with a valid latch, then stall 3 cycles
      drive(1'b1, 32'h1C, 1'b0);
      tick(); expect_state("redir1c", 32'h1C, exp_bubble(), 32'd2);
      drive(1'b0, 32'h0, 1'b0);
      tick(); expect_state("pre_stall", 32'h20, exp_valid(32'h1C, 32'd6), 32'd2);
      drive(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick(); expect_state($sformatf("stall%0d", i), 32'h20, exp_valid(32'h1C, 32'd6), 32'd2);
      end
      drive(1'b0, 32'h0, 1'b0);
      tick(); expect_state("unstall0", 32'h24, exp_valid(32'h20, 32'd7), 32'd2);
      tick(); expect_state("unstall1", 32'h28, exp_valid(32'h24, 32'd8), 32'd2);

      // Redirect and stall in the same cycle, unaligned target
      drive(1'b1, 32'h203, 1'b1);
      tick(); expect_state("redir_stall", 32'h200, exp_bubble(), 32'd3);
      drive(1'b0, 32'h0, 1'b0);
      tick(); expect_state("after_rs", 32'h204, exp_valid(32'h200, 32'd9), 32'd3);

      // Back-to-back redirects: the second sets the PC
      drive(1'b1, 32'h40, 1'b0);
      tick(); expect_state("b2b0", 32'h40, exp_bubble(), 32'd4);
      drive(1'b1, 32'h80, 1'b0);
      tick(); expect_state("b2b1", 32'h80, exp_bubble(), 32'd5);
      drive(1'b0, 32'h0, 1'b0);
      tick(); expect_state("b2b_tgt", 32'h84, exp_valid(32'h80, 32'd10), 32'd5);

      // Reset while stalled with a redirect pending
      reset = 1'b1;
      drive(1'b1, 32'h300, 1'b1);
      tick(); expect_state("mid_reset", 32'h0, exp_bubble(), 32'd0);
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      tick(); expect_state("post_reset", 32'h04, exp_valid(32'h00, 32'd1), 32'd0);

      // PC wrap at the top of the address space
      drive(1'b1, 32'hFFFF_FFFF, 1'b0);
      tick(); expect_state("wrap_redir", 32'hFFFF_FFFC, exp_bubble(), 32'd1);
      drive(1'b0, 32'h0, 1'b0);
      tick(); expect_state("wrap_top", 32'h0, exp_valid(32'hFFFF_FFFC, 32'd2), 32'd1);
      tick(); expect_state("wrap_zero", 32'h04, exp_valid(32'h0, 32'd3), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
